// File: rtl/cacheline_adaptor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_adaptor_pkg
// Description : Shared types and constants for the cache-line <-> memory-burst
//               adaptor. This package holds the FSM state encoding and the
//               line/burst geometry used by the interface and the adaptor.
// Revision    : 1.0 - initial release
// ============================================================================
package cacheline_adaptor_pkg;

    localparam int LINE_W   = 256;              // cache line width in bits
    localparam int BURST_W  = 64;               // memory burst width in bits
    localparam int BURSTS   = LINE_W / BURST_W; // bursts per cache line
    localparam int ADDR_W   = 32;               // byte address width
    localparam int OFFSET_W = 5;                // byte offset within a 32-byte line

    // Adaptor transfer states. Encoding is fixed so waveforms stay readable.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cacheline_adaptor_if.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_adaptor_if
// Description : Bundles the cache-side and memory-side signals of the cache
//               line adaptor.
//   Cache side : line_i, line_o, address_i, read_i, write_i, resp_o
//   Memory side: burst_i, burst_o, address_o, read_o, write_o, resp_i
//   Modports   : slave  - the adaptor's view (consumes *_i, drives *_o)
//                master - the environment's view (drives *_i, consumes *_o)
// Revision    : 1.0 - initial release
// ============================================================================
interface cacheline_adaptor_if
    import cacheline_adaptor_pkg::*;
#(
    parameter int s_line  = LINE_W,
    parameter int s_burst = BURST_W
) ();

    // Cache side
    logic [s_line-1:0]  line_i;
    logic [s_line-1:0]  line_o;
    logic [ADDR_W-1:0]  address_i;
    logic               read_i;
    logic               write_i;
    logic               resp_o;

    // Memory side
    logic [s_burst-1:0] burst_i;
    logic [s_burst-1:0] burst_o;
    logic [ADDR_W-1:0]  address_o;
    logic               read_o;
    logic               write_o;
    logic               resp_i;

    modport slave (
        input  line_i,
        input  address_i,
        input  read_i,
        input  write_i,
        output line_o,
        output resp_o,
        input  burst_i,
        input  resp_i,
        output burst_o,
        output address_o,
        output read_o,
        output write_o
    );

    modport master (
        output line_i,
        output address_i,
        output read_i,
        output write_i,
        input  line_o,
        input  resp_o,
        output burst_i,
        output resp_i,
        input  burst_o,
        input  address_o,
        input  read_o,
        input  write_o
    );

endinterface
`default_nettype wire

// File: rtl/cacheline_adaptor.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_adaptor
// Description : Converts single-cycle cache line requests into a sequence of
//               BURSTS memory bursts and back. A write streams the latched line
//               out lowest burst first; a read assembles the incoming bursts
//               into the line buffer lowest burst first. Memory may insert
//               any number of idle (resp_i=0) cycles between bursts.
// Ports       : clk - rising-edge clock
//               rst - asynchronous, active-low reset
//               bus - cacheline_adaptor_if.slave (cache and memory signals)
// Revision    : 1.0 - initial release
// ============================================================================
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
#(
    parameter int s_line  = LINE_W,
    parameter int s_burst = BURST_W
) (
    input  wire logic           clk,
    input  wire logic           rst,
    cacheline_adaptor_if.slave  bus
);

    localparam int N_BURSTS = s_line / s_burst;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                              r_state;
    state_t                              w_next_state;
    logic [1:0]                          r_count;
    // Line buffer viewed as an array of bursts so the burst counter indexes
    // it directly; the packed layout puts burst 0 in the low bits of the line.
    logic [N_BURSTS-1:0][s_burst-1:0]    r_line_buf;
    logic [ADDR_W-1:0]                   r_addr_q;

    logic                                w_last;
    logic                                w_unused_offset;

    assign w_last = (r_count == 2'(N_BURSTS - 1));

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and request/response outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        bus.read_o   = 1'b0;
        bus.write_o  = 1'b0;
        bus.resp_o   = 1'b0;

        case (r_state)
            IDLE: begin
                // A simultaneous read and write request resolves to the write.
                if (bus.write_i) begin
                    w_next_state = WR;
                end else if (bus.read_i) begin
                    w_next_state = RD;
                end
            end
            RD: begin
                bus.read_o = 1'b1;
                if (bus.resp_i && w_last) begin
                    w_next_state = DONE;
                end
            end
            WR: begin
                bus.write_o = 1'b1;
                if (bus.resp_i && w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                bus.resp_o   = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: address latch, burst counter and line buffer.
    // Request inputs are only sampled in IDLE; resp_i is only honoured in
    // RD/WR, so stray memory responses elsewhere have no effect.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count    <= 2'd0;
            r_line_buf <= '0;
            r_addr_q   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.write_i) begin
                        r_line_buf <= bus.line_i;
                        r_addr_q   <= bus.address_i;
                        r_count    <= 2'd0;
                    end else if (bus.read_i) begin
                        r_addr_q   <= bus.address_i;
                        r_count    <= 2'd0;
                    end
                end
                RD: begin
                    if (bus.resp_i) begin
                        r_line_buf[r_count] <= bus.burst_i;
                        r_count             <= r_count + 2'd1;
                    end
                end
                WR: begin
                    if (bus.resp_i) begin
                        r_count <= r_count + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Memory always sees a line-aligned address.
    assign bus.address_o = {r_addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};

    // The read line is the buffer itself; it is only meaningful to the cache
    // when resp_o is high.
    assign bus.line_o = r_line_buf;

    // Outside a write the burst output parks on burst 0 so it does not toggle
    // with the counter during reads.
    assign bus.burst_o = (r_state == WR) ? r_line_buf[r_count] : r_line_buf[0];

    // The offset bits are kept in the address register but never leave it.
    assign w_unused_offset = ^r_addr_q[OFFSET_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adaptor.sv
`default_nettype none
// ============================================================================
// Module      : tb_cacheline_adaptor
// Description : Self-checking bench for cacheline_adaptor. A table of
//               per-cycle vectors covers read, write, read+write priority,
//               stray responses and a gapped read; hand-written sequences
//               cover reset behaviour and recovery after a mid-transfer reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cacheline_adaptor;
    import cacheline_adaptor_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    cacheline_adaptor_if bus ();

    cacheline_adaptor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0]  Z   = 64'h0;
    localparam logic [255:0] Z2  = 256'h0;
    localparam logic [63:0]  B11 = 64'h1111_1111_1111_1111;
    localparam logic [63:0]  B22 = 64'h2222_2222_2222_2222;
    localparam logic [63:0]  B33 = 64'h3333_3333_3333_3333;
    localparam logic [63:0]  B44 = 64'h4444_4444_4444_4444;
    localparam logic [63:0]  B55 = 64'h5555_5555_5555_5555;
    localparam logic [63:0]  B66 = 64'h6666_6666_6666_6666;
    localparam logic [63:0]  B77 = 64'h7777_7777_7777_7777;
    localparam logic [63:0]  B88 = 64'h8888_8888_8888_8888;
    localparam logic [63:0]  BAA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0]  BBB = 64'hBBBB_BBBB_BBBB_BBBB;
    localparam logic [63:0]  BCC = 64'hCCCC_CCCC_CCCC_CCCC;
    localparam logic [63:0]  BDD = 64'hDDDD_DDDD_DDDD_DDDD;
    localparam logic [63:0]  BEE = 64'hEEEE_EEEE_EEEE_EEEE;
    localparam logic [63:0]  BFF = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0]  B01 = 64'h0101_0101_0101_0101;
    localparam logic [63:0]  B02 = 64'h0202_0202_0202_0202;
    localparam logic [63:0]  B03 = 64'h0303_0303_0303_0303;
    localparam logic [63:0]  B04 = 64'h0404_0404_0404_0404;
    localparam logic [63:0]  C1  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0]  C2  = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0]  C3  = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0]  C4  = 64'hCAFE_F00D_8000_0000;

    // One clock cycle: inputs applied before the edge, outputs expected after.
    // req/exp flags are {read, write, resp}.
    typedef struct {
        logic [2:0]   req;
        logic [63:0]  bi;
        logic [255:0] li;
        logic [31:0]  ai;
        logic [2:0]   exp;
        logic [63:0]  e_bo;
        logic [31:0]  e_ao;
        logic [255:0] e_lo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [2:0] req, input logic [63:0] bi,
                                input logic [255:0] li, input logic [31:0] ai,
                                input logic [2:0] exp, input logic [63:0] e_bo,
                                input logic [31:0] e_ao, input logic [255:0] e_lo);
        vec_t v;
        v.req  = req;  v.bi   = bi;   v.li   = li;   v.ai = ai;
        v.exp  = exp;  v.e_bo = e_bo; v.e_ao = e_ao; v.e_lo = e_lo;
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] exp, input logic [63:0] e_bo,
                             input logic [31:0] e_ao, input logic [255:0] e_lo);
        check({tag, " read_o"},    {255'h0, bus.read_o},  {255'h0, exp[2]});
        check({tag, " write_o"},   {255'h0, bus.write_o}, {255'h0, exp[1]});
        check({tag, " resp_o"},    {255'h0, bus.resp_o},  {255'h0, exp[0]});
        check({tag, " burst_o"},   {192'h0, bus.burst_o},  {192'h0, e_bo});
        check({tag, " address_o"}, {224'h0, bus.address_o}, {224'h0, e_ao});
        check({tag, " line_o"},    bus.line_o, e_lo);
    endtask

    task automatic drive(input logic [2:0] req, input logic [63:0] bi,
                         input logic [255:0] li, input logic [31:0] ai);
        bus.read_i    = req[2];
        bus.write_i   = req[1];
        bus.resp_i    = req[0];
        bus.burst_i   = bi;
        bus.line_i    = li;
        bus.address_i = ai;
    endtask

    initial begin
        logic [255:0] rl, wl, l2, gl, pl;
        logic [63:0]  pb [4];
        rl = {B44, B33, B22, B11};
        wl = {BDD, BCC, BBB, BAA};
        l2 = {B04, B03, B02, B01};
        gl = {C4, C3, C2, C1};
        pl = {B88, B77, B66, B55};
        pb[0] = B55; pb[1] = B66; pb[2] = B77; pb[3] = B88;

        // ---------------- Reset: requests and responses are ignored -------
        drive(3'b111, BFF, wl, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        check_all("reset1", 3'b000, Z, 32'h0, Z2);
        @(posedge clk); #1;
        check_all("reset2", 3'b000, Z, 32'h0, Z2);
        drive(3'b000, Z, Z2, 32'h0);
        rst = 1'b1;

        // ---------------- Vector table ----------------
        // Read 0x1234_5678, four back-to-back bursts.
        vecs.push_back(mk(3'b100, Z,   Z2, 32'h1234_5678, 3'b100, Z,   32'h1234_5660, Z2));
        vecs.push_back(mk(3'b101, B11, Z2, 32'h1234_5678, 3'b100, B11, 32'h1234_5660, {Z, Z, Z, B11}));
        vecs.push_back(mk(3'b101, B22, Z2, 32'h1234_5678, 3'b100, B11, 32'h1234_5660, {Z, Z, B22, B11}));
        vecs.push_back(mk(3'b101, B33, Z2, 32'h1234_5678, 3'b100, B11, 32'h1234_5660, {Z, B33, B22, B11}));
        vecs.push_back(mk(3'b101, B44, Z2, 32'h1234_5678, 3'b001, B11, 32'h1234_5660, rl));
        vecs.push_back(mk(3'b000, Z,   Z2, 32'h0,         3'b000, B11, 32'h1234_5660, rl));
        // Stray memory responses while idle.
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(3'b001, BFF, Z2, 32'h0, 3'b000, B11, 32'h1234_5660, rl));
        // Write 0x0000_ABCD; request lines glitch mid-transfer.
        vecs.push_back(mk(3'b010, Z, wl, 32'h0000_ABCD, 3'b010, BAA, 32'h0000_ABC0, wl));
        vecs.push_back(mk(3'b011, Z, wl, 32'h0000_ABCD, 3'b010, BBB, 32'h0000_ABC0, wl));
        vecs.push_back(mk(3'b101, Z, Z2, 32'h0,         3'b010, BCC, 32'h0000_ABC0, wl));
        vecs.push_back(mk(3'b011, Z, wl, 32'h0000_ABCD, 3'b010, BDD, 32'h0000_ABC0, wl));
        vecs.push_back(mk(3'b011, Z, wl, 32'h0000_ABCD, 3'b001, BAA, 32'h0000_ABC0, wl));
        vecs.push_back(mk(3'b000, Z, Z2, 32'h0,         3'b000, BAA, 32'h0000_ABC0, wl));
        // Read and write together: write wins.
        vecs.push_back(mk(3'b110, Z, l2, 32'hFFFF_FFFF, 3'b010, B01, 32'hFFFF_FFE0, l2));
        vecs.push_back(mk(3'b111, Z, l2, 32'hFFFF_FFFF, 3'b010, B02, 32'hFFFF_FFE0, l2));
        vecs.push_back(mk(3'b111, Z, l2, 32'hFFFF_FFFF, 3'b010, B03, 32'hFFFF_FFE0, l2));
        vecs.push_back(mk(3'b111, Z, l2, 32'hFFFF_FFFF, 3'b010, B04, 32'hFFFF_FFE0, l2));
        vecs.push_back(mk(3'b111, Z, l2, 32'hFFFF_FFFF, 3'b001, B01, 32'hFFFF_FFE0, l2));
        vecs.push_back(mk(3'b000, Z, Z2, 32'h0,         3'b000, B01, 32'hFFFF_FFE0, l2));
        // Gapped read 0x8000_001F, resp pattern 1,0,0,1,1,0,1.
        vecs.push_back(mk(3'b100, Z,   Z2, 32'h8000_001F, 3'b100, B01, 32'h8000_0000, l2));
        vecs.push_back(mk(3'b101, C1,  Z2, 32'h8000_001F, 3'b100, C1,  32'h8000_0000, {B04, B03, B02, C1}));
        vecs.push_back(mk(3'b100, BEE, Z2, 32'h8000_001F, 3'b100, C1,  32'h8000_0000, {B04, B03, B02, C1}));
        vecs.push_back(mk(3'b110, BEE, Z2, 32'h8000_001F, 3'b100, C1,  32'h8000_0000, {B04, B03, B02, C1}));
        vecs.push_back(mk(3'b101, C2,  Z2, 32'h8000_001F, 3'b100, C1,  32'h8000_0000, {B04, B03, C2, C1}));
        vecs.push_back(mk(3'b101, C3,  Z2, 32'h8000_001F, 3'b100, C1,  32'h8000_0000, {B04, C3, C2, C1}));
        vecs.push_back(mk(3'b100, BEE, Z2, 32'h8000_001F, 3'b100, C1,  32'h8000_0000, {B04, C3, C2, C1}));
        vecs.push_back(mk(3'b101, C4,  Z2, 32'h8000_001F, 3'b001, C1,  32'h8000_0000, gl));
        vecs.push_back(mk(3'b000, Z,   Z2, 32'h0,         3'b000, C1,  32'h8000_0000, gl));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].req, vecs[i].bi, vecs[i].li, vecs[i].ai);
            @(posedge clk); #1;
            check_all($sformatf("vec%0d", i), vecs[i].exp, vecs[i].e_bo, vecs[i].e_ao, vecs[i].e_lo);
        end

        // ---------------- Reset after two read bursts ----------------
        drive(3'b100, Z, Z2, 32'h5555_5555);
        @(posedge clk); #1;
        drive(3'b101, B11, Z2, 32'h5555_5555);
        @(posedge clk); #1;
        drive(3'b101, B22, Z2, 32'h5555_5555);
        @(posedge clk); #1;
        check("midrst pre read_o", {255'h0, bus.read_o}, {255'h0, 1'b1});
        #2 rst = 1'b0;
        #1;
        check_all("midrst async", 3'b000, Z, 32'h0, Z2);
        drive(3'b001, BFF, Z2, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_all($sformatf("postrst%0d", i), 3'b000, Z, 32'h0, Z2);
        end

        // ---------------- New read after reset ----------------
        drive(3'b100, Z, Z2, 32'h0BAD_F00D);
        @(posedge clk); #1;
        check_all("rerd req", 3'b100, Z, 32'h0BAD_F000, Z2);
        for (int i = 0; i < 4; i++) begin
            drive(3'b101, pb[i], Z2, 32'h0BAD_F00D);
            @(posedge clk); #1;
            check($sformatf("rerd resp_o %0d", i), {255'h0, bus.resp_o}, {255'h0, (i == 3)});
            check($sformatf("rerd read_o %0d", i), {255'h0, bus.read_o}, {255'h0, (i != 3)});
        end
        check("rerd line_o", bus.line_o, pl);
        drive(3'b000, Z, Z2, 32'h0);
        @(posedge clk); #1;
        check_all("rerd idle", 3'b000, B55, 32'h0BAD_F000, pl);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have parameter s_line, default 256: cache line width in bits.
REQ-002 SHALL have parameter s_burst, default 64: memory burst width in bits; the line is s_line/s_burst = 4 bursts.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port line_i  input  256  write line from the cache (pmem_wdata).
REQ-006 SHALL have port line_o  output  256  read line to the cache (pmem_rdata).
REQ-007 SHALL have port address_i  input  32  line address from the cache (pmem_address).
REQ-008 SHALL have ports read_i and write_i, each input 1: cache line read and write requests.
REQ-009 SHALL have port resp_o  output  1  line transfer complete (pmem_resp).
REQ-010 SHALL have port burst_i  input  64  burst data from memory.
REQ-011 SHALL have port burst_o  output  64  burst data to memory.
REQ-012 SHALL have port address_o  output  32  line-aligned address to memory.
REQ-013 SHALL have ports read_o and write_o, each output 1: memory read and write requests.
REQ-014 SHALL have port resp_i  input  1  memory burst valid or accepted.

Function
REQ-015 SHALL implement FSM states IDLE, RD, WR, DONE; read_o=1 only in RD; write_o=1 only in WR; resp_o=1 only in DONE.
REQ-016 IDLE: write_i=1 -> latch line_i into line_buf and address_i into addr_q; clear count; go to WR.
REQ-017 IDLE: read_i=1 with write_i=0 -> latch address_i into addr_q; clear count; go to RD.
REQ-018 IDLE: write_i=1 and read_i=1 together -> SHALL take the write.
REQ-019 address_o SHALL equal {addr_q[31:5], 5'b0} at all times.
REQ-020 RD: each cycle with resp_i=1 stores burst_i into line_buf[64*count +: 64] and increments count.
REQ-021 RD: resp_i=1 with count==3 -> go to DONE.
REQ-022 WR: burst_o SHALL equal line_buf[64*count +: 64]; each cycle with resp_i=1 increments count.
REQ-023 WR: resp_i=1 with count==3 -> go to DONE.
REQ-024 RD/WR: resp_i=0 cycles (gaps) hold count and line_buf; gaps of any length SHALL be tolerated.
REQ-025 DONE SHALL last exactly one cycle, then go to IDLE; line_o SHALL be wired to line_buf continuously.
REQ-026 resp_i in IDLE or DONE SHALL be ignored.
REQ-027 read_i/write_i changes while in RD/WR SHALL be ignored; the cache holds its request until resp_o.
REQ-028 Minimum latency: request at edge t, back-to-back resp_i -> resp_o high in cycle t+5.
REQ-029 burst_o SHALL be line_buf[63:0] outside WR.

Reset
REQ-030 rst=0 SHALL immediately force state=IDLE, count=0, line_buf=0, addr_q=0, even mid-transfer.
REQ-031 During reset read_o=0, write_o=0, resp_o=0, line_o=0, burst_o=0, address_o=0.
REQ-032 A reset mid-transfer SHALL abandon the transfer and SHALL NOT emit resp_o.

Structure
REQ-033 A shared package SHALL hold the state enum typedef and the constants LINE_W=256, BURST_W=64, BURSTS=4.
REQ-034 The block SHALL be a single module with a 2-bit count; no sub-module.

Verification
REQ-035 Read: address_i=0x1234_5678, then resp_i on 4 consecutive cycles with bursts 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> address_o=0x1234_5660; line_o={0x44..44, 0x33..33, 0x22..22, 0x11..11}; resp_o high for exactly 1 cycle at t+5.
REQ-036 Write: line_i={0xDD.., 0xCC.., 0xBB.., 0xAA..}, resp_i continuous -> burst_o sequence AA, BB, CC, DD; write_o high 4 cycles; resp_o pulses once.
REQ-037 Gapped read: resp_i pattern 1,0,0,1,1,0,1 -> exactly 4 bursts captured in order; resp_o follows the 4th burst.
REQ-038 read_i=write_i=1 in IDLE -> write_o asserts and read_o stays 0.
REQ-039 rst driven low after 2 read bursts -> read_o drops asynchronously, no resp_o; a new read after reset completes with correct data.
REQ-040 Spurious resp_i=1 in IDLE for 3 cycles -> no state change and no resp_o.
